// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: round-robin writeback sharing, a pending-write
// scoreboard for RAW stalls, and a post-reset zero-fill of x1..x31.
module rf_writeback_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [5*NUM_REQ-1:0]          req_rd_in,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic                          mark_valid_in,
  input  logic [4:0]                    mark_rd_in,
  input  logic [4:0]                    rs1_sel_in,
  input  logic [4:0]                    rs2_sel_in,
  output logic                          rs1_busy_out,
  output logic                          rs2_busy_out,
  output logic                          rf_write_enable_out,
  output logic [4:0]                    rf_rd_sel_out,
  output logic [DATA_WIDTH-1:0]         rf_write_data_out,
  output logic                          init_done_out
);

  localparam int unsigned RD_W     = 5;
  localparam int unsigned PTR_W    = $clog2(NUM_REQ);
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [RD_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  we_q, we_d;
  logic [RD_W-1:0]       rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [RD_W-1:0]       sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // Round-robin search starting at ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid_in[wrap_idx(32'(ptr_q) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(32'(ptr_q) + k);
      end
    end
  end

  assign sel_rd   = req_rd_in[RD_W*32'(grant_idx) +: RD_W];
  assign sel_data = req_data_in[DATA_WIDTH*32'(grant_idx) +: DATA_WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next state: leave INIT on the edge that presents x31
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cnt_q == RD_W'(NUM_REGS - 1)) state_d = ST_RUN;
  end

  // Outputs and next values of the write port, pointer, counter and scoreboard
  always_comb begin
    req_ready_out = '0;
    we_d          = 1'b0;
    rd_d          = rd_q;
    data_d        = data_q;
    done_d        = done_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    pending_d     = pending_q;
    case (state_q)
      ST_INIT: begin
        we_d   = 1'b1;
        rd_d   = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + RD_W'(1);
        if (cnt_q == RD_W'(NUM_REGS - 1)) done_d = 1'b1;
      end
      ST_RUN: begin
        if (grant_found) begin
          req_ready_out[grant_idx] = 1'b1;
          ptr_d = wrap_idx(32'(grant_idx) + 1);
          if (sel_rd != '0) begin
            we_d              = 1'b1;
            rd_d              = sel_rd;
            data_d            = sel_data;
            pending_d[sel_rd] = 1'b0;
          end
        end
        // A mark on the same edge as the clear is a newer producer, so it wins
        if (mark_valid_in && mark_rd_in != '0) pending_d[mark_rd_in] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      cnt_q     <= RD_W'(1);
      pending_q <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      done_q    <= ~CLEAR_ON_RESET;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // A presented-but-unstored write still counts as busy
  assign rs1_busy_out = (state_q == ST_INIT) ||
                        ((rs1_sel_in != '0) && (pending_q[rs1_sel_in] || (we_q && rd_q == rs1_sel_in)));
  assign rs2_busy_out = (state_q == ST_INIT) ||
                        ((rs2_sel_in != '0) && (pending_q[rs2_sel_in] || (we_q && rd_q == rs2_sel_in)));

  assign rf_write_enable_out = we_q;
  assign rf_rd_sel_out       = rd_q;
  assign rf_write_data_out   = data_q;
  assign init_done_out       = done_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: vector table for arbitration/scoreboard, a queue of
// expected write-port values, and hand sequences for clear, hazard and mid-run reset.
module tb_rf_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic [4:0]  rs1_sel, rs2_sel;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        init_done;

  rf_writeback_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_in        (req_valid),
    .req_rd_in           (req_rd),
    .req_data_in         (req_data),
    .req_ready_out       (req_ready),
    .mark_valid_in       (mark_valid),
    .mark_rd_in          (mark_rd),
    .rs1_sel_in          (rs1_sel),
    .rs2_sel_in          (rs2_sel),
    .rs1_busy_out        (rs1_busy),
    .rs2_busy_out        (rs2_busy),
    .rf_write_enable_out (rf_we),
    .rf_rd_sel_out       (rf_rd),
    .rf_write_data_out   (rf_wdata),
    .init_done_out       (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen by the consumer of the write port
  logic [31:0] rf_model [32];
  always @(posedge clk) if (rf_we) rf_model[rf_rd] <= rf_wdata;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  typedef struct {
    logic [2:0] valid;
    logic [4:0] rd0, rd1, rd2;
    logic       mv;
    logic [4:0] mrd, rs1, rs2;
    logic [2:0] rdy;
    logic       b1, b2, we;
    logic [4:0] wrd;
  } vec_t;
  vec_t vecs[17];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wr_exp_t e;
    e.we = we; e.rd = rd; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    wr_exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " we"}, 32'(rf_we), 32'(e.we));
      if (e.we) begin
        check({name, " rd"}, 32'(rf_rd), 32'(e.rd));
        check({name, " data"}, rf_wdata, e.data);
      end
    end
  endtask

  function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] rd0, input logic [4:0] rd1,
                              input logic [4:0] rd2, input logic mv, input logic [4:0] mrd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] rdy,
                              input logic b1, input logic b2, input logic we, input logic [4:0] wrd);
    vec_t v;
    v.valid = valid; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2; v.mv = mv; v.mrd = mrd;
    v.rs1 = rs1; v.rs2 = rs2; v.rdy = rdy; v.b1 = b1; v.b2 = b2; v.we = we; v.wrd = wrd;
    return v;
  endfunction

  function automatic logic [31:0] dfun(input int n, input int i);
    return 32'hA500_0000 | (32'(n) << 8) | 32'(i);
  endfunction

  // Clear sequence from reset release (called at negedge+0 with rst_n just released)
  task automatic run_clear(input string tag);
    req_valid = 3'b111; req_rd = {5'd9, 5'd9, 5'd9}; req_data = '1;
    mark_valid = 1'b1; mark_rd = 5'd4; rs1_sel = 5'd0; rs2_sel = 5'd31;
    #1;
    for (int i = 1; i <= 31; i++) begin
      check({tag, " init ready"}, 32'(req_ready), 32'd0);
      check({tag, " init busy"}, 32'(rs1_busy), 32'd1);
      push_exp(1'b1, 5'(i), 32'd0);
      @(posedge clk); #1;
      pop_check({tag, " clear"});
      check({tag, " init_done"}, 32'(init_done), 32'(i == 31));
      if (i < 31) begin @(negedge clk); #1; end
    end
    check({tag, " first ready"}, 32'(req_ready), 32'b001);
    check({tag, " x31 presented busy"}, 32'(rs2_busy), 32'd1);
    req_valid = 3'b000; mark_valid = 1'b0; rs1_sel = 5'd4;
    #1;
    check({tag, " mark ignored in init"}, 32'(rs1_busy), 32'd0);
    @(negedge clk);
    push_exp(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    pop_check({tag, " idle"});
    for (int j = 1; j < 32; j++) check({tag, " rf zero"}, rf_model[j], 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // {valid, rd0, rd1, rd2, mark_v, mark_rd, rs1, rs2, ready, busy1, busy2, we, wrd}
    vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 31, 1, 3'b000, 0, 0, 0, 0);
    vecs[1]  = mk(3'b111, 1, 2, 3, 0, 0,  0, 0, 3'b001, 0, 0, 1, 1);
    vecs[2]  = mk(3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b010, 1, 0, 1, 2);
    vecs[3]  = mk(3'b111, 1, 2, 3, 0, 0,  0, 0, 3'b100, 0, 0, 1, 3);
    vecs[4]  = mk(3'b111, 1, 2, 3, 0, 0,  3, 0, 3'b001, 1, 0, 1, 1);
    vecs[5]  = mk(3'b111, 1, 2, 3, 0, 0,  0, 0, 3'b010, 0, 0, 1, 2);
    vecs[6]  = mk(3'b111, 1, 2, 3, 0, 0,  0, 0, 3'b100, 0, 0, 1, 3);
    vecs[7]  = mk(3'b110, 0, 4, 8, 1, 5,  5, 3, 3'b010, 0, 1, 1, 4);
    vecs[8]  = mk(3'b011, 6, 4, 0, 0, 0,  5, 4, 3'b001, 1, 1, 1, 6);
    vecs[9]  = mk(3'b010, 0, 0, 0, 0, 0,  5, 6, 3'b010, 1, 1, 0, 0);
    vecs[10] = mk(3'b000, 0, 0, 0, 1, 7,  7, 6, 3'b000, 0, 0, 0, 0);
    vecs[11] = mk(3'b100, 0, 0, 7, 1, 7,  7, 5, 3'b100, 1, 1, 1, 7);
    vecs[12] = mk(3'b000, 0, 0, 0, 0, 0,  7, 5, 3'b000, 1, 1, 0, 0);
    vecs[13] = mk(3'b000, 0, 0, 0, 0, 0,  7, 0, 3'b000, 1, 0, 0, 0);
    vecs[14] = mk(3'b010, 0, 5, 0, 0, 0,  5, 7, 3'b010, 1, 1, 1, 5);
    vecs[15] = mk(3'b000, 0, 0, 0, 0, 0,  5, 2, 3'b000, 1, 0, 0, 0);
    vecs[16] = mk(3'b000, 0, 0, 0, 0, 0,  5, 7, 3'b000, 0, 1, 0, 0);

    for (int j = 0; j < 32; j++) rf_model[j] = 32'hFFFF_FFFF;
    rst_n = 1'b0; req_valid = 3'b111; req_rd = '0; req_data = '0;
    mark_valid = 1'b0; mark_rd = '0; rs1_sel = 5'd0; rs2_sel = 5'd0;
    #12;
    check("reset we", 32'(rf_we), 32'd0);
    check("reset rd", 32'(rf_rd), 32'd0);
    check("reset data", rf_wdata, 32'd0);
    check("reset init_done", 32'(init_done), 32'd0);
    check("reset ready", 32'(req_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_clear("first");

    for (int n = 0; n < 17; n++) begin
      int gidx;
      @(negedge clk);
      req_valid  = vecs[n].valid;
      req_rd     = {vecs[n].rd2, vecs[n].rd1, vecs[n].rd0};
      req_data   = {dfun(n, 2), dfun(n, 1), dfun(n, 0)};
      mark_valid = vecs[n].mv;
      mark_rd    = vecs[n].mrd;
      rs1_sel    = vecs[n].rs1;
      rs2_sel    = vecs[n].rs2;
      #1;
      check($sformatf("v%0d ready", n), 32'(req_ready), 32'(vecs[n].rdy));
      check($sformatf("v%0d busy1", n), 32'(rs1_busy), 32'(vecs[n].b1));
      check($sformatf("v%0d busy2", n), 32'(rs2_busy), 32'(vecs[n].b2));
      gidx = (vecs[n].rdy == 3'b010) ? 1 : (vecs[n].rdy == 3'b100) ? 2 : 0;
      push_exp(vecs[n].we, vecs[n].wrd, dfun(n, gidx));
      @(posedge clk); #1;
      pop_check($sformatf("v%0d write", n));
    end

    // RAW hazard on x5 resolved by requester 1 with 0xDEADBEEF (ptr is 2 here)
    @(negedge clk);
    req_valid = 3'b000; mark_valid = 1'b1; mark_rd = 5'd5; rs1_sel = 5'd5; rs2_sel = 5'd0;
    push_exp(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    pop_check("hz mark");
    mark_valid = 1'b0;
    check("hz busy after mark", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    req_valid = 3'b010; req_rd = {5'd0, 5'd5, 5'd0}; req_data = {32'd0, 32'hDEAD_BEEF, 32'd0};
    #1;
    check("hz ready", 32'(req_ready), 32'b010);
    push_exp(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    pop_check("hz write");
    req_valid = 3'b000;
    check("hz busy presented", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    push_exp(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    pop_check("hz after");
    check("hz busy cleared", 32'(rs1_busy), 32'd0);
    check("hz data held", rf_wdata, 32'hDEAD_BEEF);
    check("hz rf x5", rf_model[5], 32'hDEAD_BEEF);

    // Reset mid-operation with pending x10 and a write to x12 being presented
    @(negedge clk);
    mark_valid = 1'b1; mark_rd = 5'd10; rs1_sel = 5'd10;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd12}; req_data = {32'd0, 32'd0, 32'h1234_5678};
    #1;
    check("mr ready", 32'(req_ready), 32'b001);
    push_exp(1'b1, 5'd12, 32'h1234_5678);
    @(posedge clk); #1;
    pop_check("mr write");
    mark_valid = 1'b0; req_valid = 3'b111;
    check("mr pending busy", 32'(rs1_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr we", 32'(rf_we), 32'd0);
    check("mr rd", 32'(rf_rd), 32'd0);
    check("mr data", rf_wdata, 32'd0);
    check("mr init_done", 32'(init_done), 32'd0);
    check("mr ready", 32'(req_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_clear("second");
    rs1_sel = 5'd10;
    #1;
    check("mr pending cleared", 32'(rs1_busy), 32'd0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, multiply/divide) using round-robin arbitration with a valid/ready handshake. It keeps a 32-entry pending-write scoreboard that the issue stage queries to stall on RAW hazards. After reset it runs a clear sequence that writes zero to x1..x31, because the register file has no reset of its own. It sits between the execute/memory writeback sources and the register file write inputs.

## Interface
- NUM_REQ, 3: number of writeback requesters (2..8)
- DATA_WIDTH, 32: write data width
- CLEAR_ON_RESET, 1: 1 = run the x1..x31 zero-fill after reset; 0 = enter RUN directly
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid_in  in  NUM_REQ  writeback request valid, one bit per requester
- req_rd_in  in  5*NUM_REQ  destination register per requester; requester i uses bits [5i+4:5i]
- req_data_in  in  DATA_WIDTH*NUM_REQ  write data per requester
- req_ready_out  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high
- mark_valid_in  in  1  issue stage reserves a destination
- mark_rd_in  in  5  reserved destination register
- rs1_sel_in, rs2_sel_in  in  5 each  source registers to check
- rs1_busy_out, rs2_busy_out  out  1 each  source not yet readable
- rf_write_enable_out  out  1  to register file write enable
- rf_rd_sel_out  out  5  to register file destination select
- rf_write_data_out  out  DATA_WIDTH  to register file write data
- init_done_out  out  1  clear sequence complete

## Operation
- States:
  - INIT: zero-fill of x1..x31.
  - RUN: normal arbitration.
  - Reset enters INIT when CLEAR_ON_RESET=1, else RUN.
- INIT:
  - 5-bit counter starts at 1.
  - On each clock edge: write port registers enable=1, rd=counter, data=0; counter increments.
  - On the edge that presents rd=31: go to RUN and set init_done_out=1.
  - req_ready_out is all 0; mark_valid_in is ignored; both busy outputs are forced to 1.
- RUN arbitration:
  - Round-robin pointer ptr (reset 0).
  - Grant goes to the first requester with valid=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready_out is combinational from req_valid_in and ptr. Requesters must not make valid depend on ready.
  - At most one ready bit is high per cycle; all ready bits are 0 when no valid is high.
  - On a transfer by requester g, ptr becomes (g+1) mod NUM_REQ; otherwise ptr holds.
  - A valid request that is not granted holds its rd and data stable until accepted.
- Write port (registered):
  - On a transfer with rd≠0: enable=1, rd_sel=rd, data=req data.
  - On a transfer with rd=0, or no transfer: enable=0. rd_sel and data hold their last values.
- Scoreboard pending[31:1]:
  - mark_valid_in with rd≠0 sets the bit for that rd.
  - A transfer to rd≠0 clears the bit for that rd.
  - Set and clear of the same rd on the same edge: set wins (a newer producer has issued).
  - x0 is never pending.
- Busy (combinational) for rs = rs1_sel_in or rs2_sel_in:
  - rs=0: busy=0.
  - Otherwise busy = pending[rs] OR (rf_write_enable_out AND rf_rd_sel_out==rs).
  - The second term covers the cycle in which the write is presented but not yet stored in the register file.

## Timing
- Reset values:
  - rf_write_enable_out=0, rf_rd_sel_out=0, rf_write_data_out=0.
  - pending all 0, ptr=0, counter=1.
  - init_done_out=0 when CLEAR_ON_RESET=1, else 1.
- Reset assertion mid-operation: all of the above take their reset values immediately, without waiting for a clock edge. When reset is released, the clear sequence restarts from x1.
- Clear sequence length: the 1st through 31st edges after reset release present x1..x31. The final zero lands in the register file at the 32nd edge. req_ready_out can first be high in the cycle after the 31st edge.
- Writeback latency:
  - Transfer at edge N.
  - rf_write_enable_out is high during cycle N..N+1.
  - The register file stores the value at edge N+1.
  - The pending bit clears at edge N.
- Throughput: one accepted writeback per cycle. There are no internal buffers.
- Mark to busy: a mark at edge N makes busy=1 from edge N onward.

## Test plan
- Clear sequence: reset with CLEAR_ON_RESET=1 -> 31 consecutive writes of 0 to rd=1..31, init_done_out rises with rd=31, ready stays 0 until after that edge.
- Round-robin fairness: requesters 0, 1 and 2 all continuously valid from ptr=0 -> grants 0,1,2,0,1,2, and writes appear one cycle after each grant with the matching rd and data.
- Scoreboard hazard:
  - mark rd=5, then rs1_sel_in=5 -> rs1_busy_out=1.
  - Requester 1 writes rd=5 with data 0xDEADBEEF -> busy stays 1 during the presentation cycle, then 0 afterwards; the register file holds 0xDEADBEEF.
- rd=0 and set-wins:
  - A request to rd=0 is accepted with no write enable.
  - mark rd=7 on the same edge as a writeback to rd=7 -> pending[7] stays 1.
- Mid-operation reset: assert rst_n low while pending is nonzero and a write is being presented -> outputs clear immediately; after release the clear sequence restarts at x1.
